// File: rtl/axis_fifo_status_pkg.sv
// Shared types and constants for the AXI-Stream FIFO status monitor.
package axis_fifo_status_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 16;

  typedef enum logic {
    NORMAL = 1'b0,
    HIGH   = 1'b1
  } wm_state_e;

endpackage

// File: rtl/axis_fifo_status_channel.sv
// One monitored FIFO: event counters, peak depth, watermark FSM and sticky irq cause.
module axis_fifo_status_channel
  import axis_fifo_status_pkg::*;
#(
  parameter int unsigned DW        = 9,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int unsigned HIGH_WM   = 192,
  parameter int unsigned LOW_WM    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        depth,
  input  logic                 overflow,
  input  logic                 bad_frame,
  input  logic                 good_frame,
  input  logic                 clear,
  input  logic                 irq_ack,
  output logic [CNT_WIDTH-1:0] good_count,
  output logic [CNT_WIDTH-1:0] bad_count,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic [DW-1:0]        peak_depth,
  output logic                 almost_full,
  output logic                 irq_status
);

  wm_state_e state_q;
  wm_state_e state_d;
  logic      enter_high_c;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic                 ev);
    return (ev && (v != {CNT_WIDTH{1'b1}})) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // Watermark state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Hysteresis next-state; flags the NORMAL->HIGH edge as an interrupt cause.
  always_comb begin
    state_d      = state_q;
    enter_high_c = 1'b0;
    case (state_q)
      NORMAL: begin
        if (depth >= DW'(HIGH_WM)) begin
          state_d      = HIGH;
          enter_high_c = 1'b1;
        end
      end
      HIGH: begin
        if (depth <= DW'(LOW_WM)) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // almost_full follows the watermark state, registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (state_d == HIGH);
    end
  end

  // Event counters; clear wins over a same-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_count <= '0;
      bad_count  <= '0;
      ovf_count  <= '0;
    end else if (clear) begin
      good_count <= '0;
      bad_count  <= '0;
      ovf_count  <= '0;
    end else begin
      good_count <= sat_inc(good_count, good_frame);
      bad_count  <= sat_inc(bad_count, bad_frame);
      ovf_count  <= sat_inc(ovf_count, overflow);
    end
  end

  // Peak occupancy since last clear; clear restarts from the current depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_depth <= '0;
    end else if (clear || (depth > peak_depth)) begin
      peak_depth <= depth;
    end
  end

  // Sticky interrupt cause; a new cause beats a same-cycle acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_status <= 1'b0;
    end else if (overflow || bad_frame || enter_high_c) begin
      irq_status <= 1'b1;
    end else if (irq_ack) begin
      irq_status <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_fifo_status_monitor.sv
// Status monitor for a bank of AXI-Stream FIFOs: per-channel statistics plus one aggregate irq.
module axis_fifo_status_monitor
  import axis_fifo_status_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int unsigned HIGH_WM   = 192,
  parameter int unsigned LOW_WM    = 64,
  localparam int unsigned DW       = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*DW-1:0]        depth,
  input  logic [CHANNELS-1:0]           overflow,
  input  logic [CHANNELS-1:0]           bad_frame,
  input  logic [CHANNELS-1:0]           good_frame,
  input  logic [CHANNELS-1:0]           clear,
  input  logic [CHANNELS-1:0]           irq_mask,
  input  logic [CHANNELS-1:0]           irq_ack,
  output logic [CHANNELS*CNT_WIDTH-1:0] good_count,
  output logic [CHANNELS*CNT_WIDTH-1:0] bad_count,
  output logic [CHANNELS*CNT_WIDTH-1:0] ovf_count,
  output logic [CHANNELS*DW-1:0]        peak_depth,
  output logic [CHANNELS-1:0]           almost_full,
  output logic [CHANNELS-1:0]           irq_status,
  output logic                          irq
);

  // Reject illegal parameter combinations at elaboration.
  if (!((LOW_WM < HIGH_WM) && (HIGH_WM <= DEPTH) && (CHANNELS >= 1) && (CHANNELS <= 8))) begin : g_param_check
    $error("axis_fifo_status_monitor: illegal CHANNELS/HIGH_WM/LOW_WM/DEPTH combination");
  end

  // One independent monitor per FIFO.
  for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_ch
    axis_fifo_status_channel #(
      .DW        (DW),
      .CNT_WIDTH (CNT_WIDTH),
      .HIGH_WM   (HIGH_WM),
      .LOW_WM    (LOW_WM)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .depth       (depth[n*DW +: DW]),
      .overflow    (overflow[n]),
      .bad_frame   (bad_frame[n]),
      .good_frame  (good_frame[n]),
      .clear       (clear[n]),
      .irq_ack     (irq_ack[n]),
      .good_count  (good_count[n*CNT_WIDTH +: CNT_WIDTH]),
      .bad_count   (bad_count[n*CNT_WIDTH +: CNT_WIDTH]),
      .ovf_count   (ovf_count[n*CNT_WIDTH +: CNT_WIDTH]),
      .peak_depth  (peak_depth[n*DW +: DW]),
      .almost_full (almost_full[n]),
      .irq_status  (irq_status[n])
    );
  end

  // Aggregate interrupt from the enabled sticky causes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_status & irq_mask);
    end
  end

endmodule

// File: tb/tb_axis_fifo_status_monitor.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_axis_fifo_status_monitor;

  localparam int CH    = 4;
  localparam int DEPTH = 256;
  localparam int DW    = 9;
  localparam int CW    = 4;
  localparam int HWM   = 192;
  localparam int LWM   = 64;
  localparam int MAXC  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH*DW-1:0]  depth;
  logic [CH-1:0]     overflow, bad_frame, good_frame, clear, irq_mask, irq_ack;
  logic [CH*CW-1:0]  good_count, bad_count, ovf_count;
  logic [CH*DW-1:0]  peak_depth;
  logic [CH-1:0]     almost_full, irq_status;
  logic              irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_good[CH], m_bad[CH], m_ovf[CH], m_peak[CH];
  bit m_hi[CH], m_st[CH];
  bit m_irq;

  axis_fifo_status_monitor #(
    .CHANNELS(CH), .DEPTH(DEPTH), .CNT_WIDTH(CW), .HIGH_WM(HWM), .LOW_WM(LWM)
  ) dut (
    .clk(clk), .reset(reset), .depth(depth),
    .overflow(overflow), .bad_frame(bad_frame), .good_frame(good_frame),
    .clear(clear), .irq_mask(irq_mask), .irq_ack(irq_ack),
    .good_count(good_count), .bad_count(bad_count), .ovf_count(ovf_count),
    .peak_depth(peak_depth), .almost_full(almost_full),
    .irq_status(irq_status), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int ch, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ch%0d: observed %0d expected %0d", tag, ch, obs, exp);
    end
  endtask

  function automatic int dep(input int ch);
    return int'(depth[ch*DW +: DW]);
  endfunction

  task automatic set_depth(input int ch, input int v);
    depth[ch*DW +: DW] = DW'(v);
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_good[c] = 0; m_bad[c] = 0; m_ovf[c] = 0; m_peak[c] = 0;
      m_hi[c] = 1'b0; m_st[c] = 1'b0;
    end
    m_irq = 1'b0;
  endtask

  // Next-state of the model from the inputs presented this cycle.
  task automatic model_step();
    bit any;
    bit rise;
    int d;
    any = 1'b0;
    for (int c = 0; c < CH; c++) if (m_st[c] && irq_mask[c]) any = 1'b1;
    m_irq = any;
    for (int c = 0; c < CH; c++) begin
      d = dep(c);
      rise = 1'b0;
      if (clear[c]) begin
        m_good[c] = 0; m_bad[c] = 0; m_ovf[c] = 0; m_peak[c] = d;
      end else begin
        if (good_frame[c] && m_good[c] < MAXC) m_good[c]++;
        if (bad_frame[c]  && m_bad[c]  < MAXC) m_bad[c]++;
        if (overflow[c]   && m_ovf[c]  < MAXC) m_ovf[c]++;
        if (d > m_peak[c]) m_peak[c] = d;
      end
      if (!m_hi[c] && d >= HWM) begin
        m_hi[c] = 1'b1;
        rise = 1'b1;
      end else if (m_hi[c] && d <= LWM) begin
        m_hi[c] = 1'b0;
      end
      if (overflow[c] || bad_frame[c] || rise) m_st[c] = 1'b1;
      else if (irq_ack[c]) m_st[c] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      chk("good_count",  c, int'(good_count[c*CW +: CW]), m_good[c]);
      chk("bad_count",   c, int'(bad_count[c*CW +: CW]),  m_bad[c]);
      chk("ovf_count",   c, int'(ovf_count[c*CW +: CW]),  m_ovf[c]);
      chk("peak_depth",  c, int'(peak_depth[c*DW +: DW]), m_peak[c]);
      chk("almost_full", c, int'(almost_full[c]),         int'(m_hi[c]));
      chk("irq_status",  c, int'(irq_status[c]),          int'(m_st[c]));
    end
    chk("irq", 0, int'(irq), int'(m_irq));
  endtask

  // One clock: advance model, take the edge, compare, drop single-cycle pulses.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    overflow = '0; bad_frame = '0; good_frame = '0; clear = '0; irq_ack = '0;
  endtask

  initial begin
    reset = 1'b1;
    depth = '0;
    overflow = '0; bad_frame = '0; good_frame = '0;
    clear = '0; irq_mask = '0; irq_ack = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Saturation: 20 pulses into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      good_frame[0] = 1'b1;
      tick();
    end
    chk("sat_good", 0, int'(good_count[0 +: CW]), 15);

    // Watermark ramp on channel 0
    set_depth(0, 200); tick();
    chk("af_rise", 0, int'(almost_full[0]), 1);
    chk("irq_set", 0, int'(irq_status[0]), 1);
    irq_ack[0] = 1'b1; tick();
    set_depth(0, 100); tick();
    chk("af_hold", 0, int'(almost_full[0]), 1);
    chk("irq_once", 0, int'(irq_status[0]), 0);
    set_depth(0, 60); tick();
    chk("af_fall", 0, int'(almost_full[0]), 0);
    chk("irq_once2", 0, int'(irq_status[0]), 0);

    // Clear and bad_frame together on channel 1
    irq_ack = '1; tick();
    bad_frame[1] = 1'b1; tick();
    clear[1] = 1'b1; bad_frame[1] = 1'b1; tick();
    chk("clr_bad_cnt", 1, int'(bad_count[1*CW +: CW]), 0);
    chk("clr_bad_irq", 1, int'(irq_status[1]), 1);

    // Masked then unmasked interrupt on channel 2
    irq_ack = '1; irq_mask = '0; tick(); tick();
    overflow[2] = 1'b1; tick(); tick();
    chk("irq_masked", 2, int'(irq), 0);
    irq_mask[2] = 1'b1; tick();
    chk("irq_unmask", 2, int'(irq), 1);
    irq_ack[2] = 1'b1; tick(); tick();
    chk("irq_acked", 2, int'(irq), 0);

    // Peak tracking and clear on channel 3
    set_depth(3, 150); tick();
    chk("peak_150", 3, int'(peak_depth[3*DW +: DW]), 150);
    set_depth(3, 30); clear[3] = 1'b1; tick();
    chk("peak_clr", 3, int'(peak_depth[3*DW +: DW]), 30);
    set_depth(3, 40); tick();
    chk("peak_40", 3, int'(peak_depth[3*DW +: DW]), 40);

    // Random traffic on all channels
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) set_depth(c, $urandom_range(0, DEPTH));
        clear[c]   = ($urandom_range(0, 15) == 0);
        irq_ack[c] = ($urandom_range(0, 3) == 0);
      end
      good_frame = CH'($urandom);
      bad_frame  = CH'($urandom) & CH'($urandom);
      overflow   = CH'($urandom) & CH'($urandom);
      if (i % 32 == 0) irq_mask = CH'($urandom);
      if (i == 100) begin
        good_frame = '1; bad_frame = '1; overflow = '1;
      end
      tick();
    end

    // Reset in the middle of a burst
    good_frame = '1; bad_frame = '1; overflow = '1;
    tick();
    good_frame = '1; bad_frame = '1; overflow = '1;
    #2;
    reset = 1'b1;
    #1;
    for (int c = 0; c < CH; c++) begin
      chk("rst_good", c, int'(good_count[c*CW +: CW]), 0);
      chk("rst_bad",  c, int'(bad_count[c*CW +: CW]), 0);
      chk("rst_ovf",  c, int'(ovf_count[c*CW +: CW]), 0);
      chk("rst_peak", c, int'(peak_depth[c*DW +: DW]), 0);
      chk("rst_af",   c, int'(almost_full[c]), 0);
      chk("rst_st",   c, int'(irq_status[c]), 0);
    end
    chk("rst_irq", 0, int'(irq), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    overflow = '0; bad_frame = '0; good_frame = '0;
    reset = 1'b0;
    good_frame[0] = 1'b1;
    tick();
    chk("post_rst_good", 0, int'(good_count[0 +: CW]), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
